// File: rtl/fifo_rd_stream.sv
// Purpose: pops an async FIFO read port and re-presents the words as a valid/ready stream with a delivered-word counter.
// Latency: rd_en in cycle N -> word captured at the end of N+1 -> m_valid in N+2; one word per cycle sustained.
// Backpressure: m_ready low stops new pops once buffered plus in-flight words reach 2; held words stay stable.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [1:0]            buf_count,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  // Two-slot skid storage for words returned by the FIFO's registered read port.
  logic [DATA_WIDTH-1:0] slot0;
  logic [DATA_WIDTH-1:0] slot1;
  logic                  head;
  logic                  tail;
  logic                  inflight;
  logic [1:0]            count_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  // Combinational handshake terms.
  logic                  pop;
  logic                  issue;
  logic [1:0]            occ_next;

  // Pop decision: occupancy after this cycle's capture and delivery must leave room
  // for the word a new pop would return. m_ready reaches rd_en combinationally so a
  // word can be consumed and replaced in the same cycle. The pop is also held off
  // while reset is asserted, because the FIFO read side is being reset alongside.
  always_comb begin
    pop      = (count_q != 2'd0) & m_ready;
    occ_next = count_q + {1'b0, inflight} - {1'b0, pop};
    issue    = rd_rst_n & ~fifo_empty & (occ_next <= 2'd1);
  end

  assign rd_en     = issue;
  assign m_valid   = (count_q != 2'd0);
  assign m_data    = head ? slot1 : slot0;
  assign buf_count = count_q;
  assign word_cnt  = cnt_q;

  // Capture the word returned one cycle after a pop into the tail slot.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      tail  <= 1'b0;
    end else if (inflight) begin
      if (tail) begin
        slot1 <= fifo_data;
      end else begin
        slot0 <= fifo_data;
      end
      tail <= ~tail;
    end
  end

  // Advance the read side of the skid buffer whenever the consumer takes a word.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      head <= 1'b0;
    end else if (pop) begin
      head <= ~head;
    end
  end

  // Occupancy and in-flight tracking; a simultaneous capture and pop leaves count unchanged.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      count_q  <= 2'd0;
      inflight <= 1'b0;
    end else begin
      count_q  <= occ_next;
      inflight <= issue;
    end
  end

  // Wrapping count of words handed to the consumer.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      cnt_q <= '0;
    end else if (pop) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream: FIFO read-port model, per-cycle vector table for
// reset/backpressure, and directed sequences for streaming, alternating ready, sparse source, wrap and mid-reset.
module tb_fifo_rd_stream;

  logic       rd_clk;
  logic       rd_rst_n;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       rd_en;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic [1:0] buf_count;
  logic [15:0] word_cnt;

  logic       rd_en4;
  logic       m_valid4;
  logic [7:0] m_data4;
  logic [1:0] buf_count4;
  logic [3:0] word_cnt4;

  fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .rd_en(rd_en), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .buf_count(buf_count), .word_cnt(word_cnt)
  );

  fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .rd_en(rd_en4), .m_valid(m_valid4), .m_data(m_data4), .m_ready(m_ready),
    .buf_count(buf_count4), .word_cnt(word_cnt4)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic       hold_empty;

  logic        s_en;
  logic        s_valid;
  logic [7:0]  s_data;
  logic [1:0]  s_bc;
  logic [15:0] s_cnt;
  logic [3:0]  s_cnt4;

  typedef struct {
    logic        mr;
    logic        en;
    logic        vld;
    logic [7:0]  dat;
    logic        chkd;
    logic [1:0]  bc;
    logic [15:0] cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle: refresh empty flag, sample outputs mid-cycle, then model the FIFO's registered read.
  task automatic tick();
    logic en;
    fifo_empty = hold_empty || (fifo_q.size() == 0);
    @(negedge rd_clk);
    en      = rd_en;
    s_en    = rd_en;
    s_valid = m_valid;
    s_data  = m_data;
    s_bc    = buf_count;
    s_cnt   = word_cnt;
    s_cnt4  = word_cnt4;
    @(posedge rd_clk);
    #1;
    if (en && rd_rst_n) begin
      if (fifo_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL fifo_underflow: pop issued with model FIFO empty");
      end else begin
        fifo_data = fifo_q.pop_front();
      end
    end
    fifo_empty = hold_empty || (fifo_q.size() == 0);
  endtask

  task automatic do_reset();
    rd_rst_n   = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    fifo_data  = 8'h00;
    hold_empty = 1'b0;
    m_ready    = 1'b0;
    tick();
    tick();
    rd_rst_n   = 1'b1;
  endtask

  // Scoreboard: order, occupancy invariant and no pop against an empty FIFO.
  always @(negedge rd_clk) begin
    if (rd_rst_n) begin
      chk("invariant", 32'(({1'b0, dut.buf_count} + {2'b00, dut.inflight}) <= 3'd2), 32'd1);
      if (fifo_empty) chk("no_pop_when_empty", 32'(rd_en), 32'd0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got 0x%0h with none expected", m_data);
        end else begin
          chk("order", 32'(m_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[14];
    int first_en, first_v, run, maxrun, pulses;
    logic [1:0] maxbc;
    int en_q[$];

    vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0, 16'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0, 16'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 2'd1, 16'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 2'd2, 16'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 2'd2, 16'd0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 8'h01, 1'b1, 2'd2, 16'd0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 8'h02, 1'b1, 2'd1, 16'd1};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 2'd1, 16'd2};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 8'h04, 1'b1, 2'd1, 16'd3};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 8'h05, 1'b1, 2'd1, 16'd4};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 8'h06, 1'b1, 2'd1, 16'd5};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 8'h07, 1'b1, 2'd1, 16'd6};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 8'h08, 1'b1, 2'd1, 16'd7};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 16'd8};

    // Reset held while the FIFO already holds 8 words.
    rd_rst_n   = 1'b0;
    m_ready    = 1'b0;
    hold_empty = 1'b0;
    fifo_data  = 8'h00;
    for (int k = 1; k <= 8; k++) begin
      fifo_q.push_back(8'(k));
      exp_q.push_back(8'(k));
    end
    tick();
    tick();
    chk("rst_rd_en", 32'(s_en), 32'd0);
    chk("rst_m_valid", 32'(s_valid), 32'd0);
    chk("rst_m_data", 32'(s_data), 32'd0);
    chk("rst_buf_count", 32'(s_bc), 32'd0);
    chk("rst_word_cnt", 32'(s_cnt), 32'd0);

    // Release, then backpressure and drain per the vector table.
    rd_rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      m_ready = vecs[i].mr;
      tick();
      tests++;
      if (s_en !== vecs[i].en || s_valid !== vecs[i].vld ||
          (vecs[i].chkd && s_data !== vecs[i].dat) ||
          s_bc !== vecs[i].bc || s_cnt !== vecs[i].cnt) begin
        fails++;
        $display("FAIL vec%0d: got en=%b vld=%b dat=%h bc=%0d cnt=%0d expected en=%b vld=%b dat=%h bc=%0d cnt=%0d",
                 i, s_en, s_valid, s_data, s_bc, s_cnt,
                 vecs[i].en, vecs[i].vld, vecs[i].dat, vecs[i].bc, vecs[i].cnt);
      end
    end
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Streaming 0x01..0x10 with m_ready held high.
    do_reset();
    m_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      fifo_q.push_back(8'(k));
      exp_q.push_back(8'(k));
    end
    first_en = -1; first_v = -1; run = 0; maxrun = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick();
      if (s_en && first_en < 0) first_en = cyc;
      if (s_valid) begin
        if (first_v < 0) first_v = cyc;
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
    chk("stream_first_en", 32'(first_en), 32'd0);
    chk("stream_latency", 32'(first_v - first_en), 32'd2);
    chk("stream_run", 32'(maxrun), 32'd16);
    chk("stream_word_cnt", 32'(s_cnt), 32'd16);
    chk("stream_word_cnt4", 32'(s_cnt4), 32'd0);
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    // Alternating m_ready over 10 words.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      fifo_q.push_back(8'(8'h40 + k));
      exp_q.push_back(8'(8'h40 + k));
    end
    maxbc = 2'd0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      m_ready = (cyc % 2 == 0);
      tick();
      if (s_bc > maxbc) maxbc = s_bc;
    end
    chk("alt_drained", 32'(exp_q.size()), 32'd0);
    chk("alt_word_cnt", 32'(s_cnt), 32'd10);
    chk("alt_maxbc_le2", 32'(maxbc <= 2'd2), 32'd1);

    // Sparse source: fifo_empty low for single cycles, 5 cycles apart.
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      fifo_q.push_back(8'(8'hA0 + k));
      exp_q.push_back(8'(8'hA0 + k));
    end
    pulses = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      hold_empty = !(cyc % 5 == 1);
      tick();
      if (s_en) begin
        pulses++;
        en_q.push_back(cyc);
      end
      if (s_valid) begin
        if (en_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sparse_orphan: m_valid at cycle %0d with no pop outstanding", cyc);
        end else begin
          chk("sparse_latency", 32'(cyc - en_q.pop_front()), 32'd2);
        end
      end
    end
    hold_empty = 1'b0;
    chk("sparse_pulses", 32'(pulses), 32'd4);
    chk("sparse_drained", 32'(exp_q.size()), 32'd0);

    // Counter wrap at 4 bits: 17 words.
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      fifo_q.push_back(8'(8'h10 + k));
      exp_q.push_back(8'(8'h10 + k));
    end
    for (int cyc = 0; cyc < 40; cyc++) tick();
    chk("wrap_word_cnt4", 32'(s_cnt4), 32'd1);
    chk("wrap_word_cnt16", 32'(s_cnt), 32'd17);
    chk("wrap_drained", 32'(exp_q.size()), 32'd0);

    // Mid-operation reset with one word buffered and one in flight.
    m_ready = 1'b0;
    for (int k = 0; k < 3; k++) fifo_q.push_back(8'(8'hE0 + k));
    tick();
    tick();
    chk("mid_pre_occ", 32'({dut.buf_count, dut.inflight}), 32'b011);
    rd_rst_n = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    #1;
    chk("mid_rd_en", 32'(rd_en), 32'd0);
    chk("mid_m_valid", 32'(m_valid), 32'd0);
    chk("mid_m_data", 32'(m_data), 32'd0);
    chk("mid_buf_count", 32'(buf_count), 32'd0);
    chk("mid_word_cnt", 32'(word_cnt), 32'd0);
    chk("mid_word_cnt4", 32'(word_cnt4), 32'd0);
    chk("mid_inflight", 32'(dut.inflight), 32'd0);
    tick();
    rd_rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'({s_en, s_valid}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
